// File: rtl/i2c_target_mem_if.sv
// Bus bundle for the I2C target: oversampled SCL/SDA in, open-drain SDA drive out,
// write-strobe observation and a combinational memory peek port.
interface i2c_target_mem_if #(
  parameter int MEM_AW = 3,
  parameter int DATA_W = 8
);
  logic              scl_in;
  logic              sda_in;
  logic              sda_out;
  logic              busy;
  logic              wr_strobe;
  logic [MEM_AW-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [MEM_AW-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output scl_in, sda_in, dbg_addr,
    input  sda_out, busy, wr_strobe, wr_addr, wr_data, dbg_data
  );

  modport slave (
    input  scl_in, sda_in, dbg_addr,
    output sda_out, busy, wr_strobe, wr_addr, wr_data, dbg_data
  );
endinterface

// File: rtl/i2c_target_mem.sv
// I2C target with a 2**MEM_AW byte register file: pointer-then-data writes, auto-increment reads.
// SCL/SDA pin change reaches the FSM 3 clocks later; no backpressure beyond ACK/NACK on the bus.
module i2c_target_mem #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         MEM_AW      = 3,
  parameter int         DATA_W      = 8
) (
  input  logic            i2c_core_clk,
  input  logic            rst_n,
  i2c_target_mem_if.slave bus
);
  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_IGNORE
  } state_t;

  state_t            r_state, w_nxt_state;
  logic              r_scl_s1, r_scl_s2, r_scl_d;
  logic              r_sda_s1, r_sda_s2, r_sda_d;
  logic [3:0]        r_cnt, w_nxt_cnt;
  logic [DATA_W-1:0] r_shift, w_nxt_shift;
  logic              r_sda_out, w_nxt_sda;
  logic [MEM_AW-1:0] r_ptr, w_nxt_ptr, w_ptr_inc;
  logic              r_busy, w_nxt_busy;
  logic              w_wr_en;
  logic [DATA_W-1:0] w_rx_byte, w_mem_cur, w_mem_inc;
  logic              r_wr_strobe;
  logic [MEM_AW-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_scl_rise, w_scl_fall, w_start, w_stop;

  // Synchronizers idle high so a reset never fabricates a START/STOP
  always_ff @(posedge i2c_core_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= bus.scl_in;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= bus.sda_in;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & ~r_sda_s2 & r_sda_d;
  assign w_stop     = r_scl_s2 & r_scl_d & r_sda_s2 & ~r_sda_d;

  assign w_rx_byte  = {r_shift[DATA_W-2:0], r_sda_s2};
  assign w_ptr_inc  = r_ptr + MEM_AW'(1);
  assign w_mem_cur  = r_mem[r_ptr];
  assign w_mem_inc  = r_mem[w_ptr_inc];

  always_ff @(posedge i2c_core_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt_state;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_shift = r_shift;
    w_nxt_sda   = r_sda_out;
    w_nxt_ptr   = r_ptr;
    w_nxt_busy  = r_busy;
    w_wr_en     = 1'b0;

    if (w_start) begin
      w_nxt_state = S_ADDR;
      w_nxt_cnt   = 4'd0;
      w_nxt_sda   = 1'b1;
    end else if (w_stop) begin
      w_nxt_state = S_IDLE;
      w_nxt_sda   = 1'b1;
      w_nxt_busy  = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (w_scl_rise) begin
            w_nxt_shift = w_rx_byte;
            w_nxt_cnt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_nxt_cnt = 4'd0;
              if (r_state == S_ADDR) begin
                if (w_rx_byte[7:1] == TARGET_ADDR && w_rx_byte[7:1] != 7'd0) begin
                  w_nxt_state = S_ADDR_ACK;
                  w_nxt_busy  = 1'b1;
                end else begin
                  w_nxt_state = S_IGNORE;
                end
              end else if (r_state == S_PTR) begin
                w_nxt_ptr   = w_rx_byte[MEM_AW-1:0];
                w_nxt_state = S_PTR_ACK;
              end else begin
                w_wr_en     = 1'b1;
                w_nxt_ptr   = w_ptr_inc;
                w_nxt_state = S_WDATA_ACK;
              end
            end
          end
        end
        // First fall pulls SDA low, second fall releases it and ends the ACK slot
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (r_sda_out) begin
              w_nxt_sda = 1'b0;
            end else begin
              w_nxt_sda = 1'b1;
              w_nxt_cnt = 4'd0;
              if (r_state == S_ADDR_ACK && r_shift[0]) begin
                w_nxt_sda   = w_mem_cur[DATA_W-1];
                w_nxt_shift = {w_mem_cur[DATA_W-2:0], 1'b0};
                w_nxt_cnt   = 4'd1;
                w_nxt_state = S_RDATA;
              end else if (r_state == S_ADDR_ACK) begin
                w_nxt_state = S_PTR;
              end else begin
                w_nxt_state = S_WDATA;
              end
            end
          end
        end
        S_RDATA: begin
          if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_nxt_sda   = 1'b1;
              w_nxt_cnt   = 4'd0;
              w_nxt_state = S_RACK;
            end else begin
              w_nxt_sda   = r_shift[DATA_W-1];
              w_nxt_shift = {r_shift[DATA_W-2:0], 1'b0};
              w_nxt_cnt   = r_cnt + 4'd1;
            end
          end
        end
        S_RACK: begin
          if (w_scl_rise) begin
            w_nxt_ptr = w_ptr_inc;
            if (!r_sda_s2) begin
              w_nxt_shift = w_mem_inc;
              w_nxt_cnt   = 4'd0;
              w_nxt_state = S_RDATA;
            end else begin
              w_nxt_state = S_IGNORE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i2c_core_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 4'd0;
      r_shift     <= '0;
      r_sda_out   <= 1'b1;
      r_ptr       <= '0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_cnt       <= w_nxt_cnt;
      r_shift     <= w_nxt_shift;
      r_sda_out   <= w_nxt_sda;
      r_ptr       <= w_nxt_ptr;
      r_busy      <= w_nxt_busy;
      r_wr_strobe <= w_wr_en;
      if (w_wr_en) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= w_rx_byte;
      end
    end
  end

  always_ff @(posedge i2c_core_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[r_ptr] <= w_rx_byte;
    end
  end

  assign bus.sda_out   = r_sda_out;
  assign bus.busy      = r_busy;
  assign bus.wr_strobe = r_wr_strobe;
  assign bus.wr_addr   = r_wr_addr;
  assign bus.wr_data   = r_wr_data;
  assign bus.dbg_data  = r_mem[bus.dbg_addr];
endmodule

// File: tb/tb_i2c_target_mem.sv
// Bench for i2c_target_mem: the bench acts as I2C controller; a byte-array model tracks memory.
module tb_i2c_target_mem;
  logic clk;
  logic rst_n;

  i2c_target_mem_if bus ();

  i2c_target_mem dut (
    .i2c_core_clk (clk),
    .rst_n        (rst_n),
    .bus          (bus)
  );

  typedef struct packed {
    logic [6:0]      addr;
    logic            rd;
    logic [7:0]      ptr;
    logic [2:0]      n;
    logic [3:0][7:0] d;
    logic            ack;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  m [8];
  int          strobe_cnt = 0;
  logic [2:0]  last_wa;
  logic [7:0]  last_wd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_strobe) begin
      strobe_cnt++;
      last_wa = bus.wr_addr;
      last_wd = bus.wr_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required normal completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period: SDA set mid-low, sample target SDA at the end of the high phase
  task automatic send_bit(input logic b, output logic s);
    wclk(4);
    bus.sda_in = b;
    wclk(4);
    bus.scl_in = 1'b1;
    wclk(8);
    s = bus.sda_out;
    bus.scl_in = 1'b0;
  endtask

  task automatic i2c_start();
    wclk(4);
    bus.sda_in = 1'b1;
    wclk(4);
    bus.scl_in = 1'b1;
    wclk(8);
    bus.sda_in = 1'b0;
    wclk(8);
    bus.scl_in = 1'b0;
  endtask

  task automatic i2c_stop(input logic chk_busy);
    wclk(4);
    bus.sda_in = 1'b0;
    wclk(4);
    bus.scl_in = 1'b1;
    wclk(8);
    bus.sda_in = 1'b1;
    wclk(2);
    if (chk_busy) chk("busy_before_stop_seen", bus.busy, 1);
    wclk(1);
    if (chk_busy) chk("busy_after_stop", bus.busy, 0);
    wclk(5);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic last, output logic [7:0] b);
    logic s;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, s);
      b = {b[6:0], s};
    end
    send_bit(last, s);
  endtask

  task automatic xfer(input vec_t v, input string tag);
    logic       ack;
    logic [7:0] rb;
    int         sc0;
    int         p;
    sc0 = strobe_cnt;
    i2c_start();
    wr_byte({v.addr, 1'b0}, ack);
    chk($sformatf("%s_addr_ack", tag), ack, v.ack);
    chk($sformatf("%s_busy", tag), bus.busy, v.ack);
    if (v.ack) begin
      wr_byte(v.ptr, ack);
      chk($sformatf("%s_ptr_ack", tag), ack, 1);
      p = v.ptr % 8;
      if (!v.rd) begin
        for (int i = 0; i < int'(v.n); i++) begin
          wr_byte(v.d[i], ack);
          chk($sformatf("%s_data%0d_ack", tag, i), ack, 1);
          m[p] = v.d[i];
          p = (p + 1) % 8;
        end
      end else begin
        i2c_start();
        wr_byte({v.addr, 1'b1}, ack);
        chk($sformatf("%s_raddr_ack", tag), ack, 1);
        for (int i = 0; i < int'(v.n); i++) begin
          rd_byte(i == int'(v.n) - 1, rb);
          chk($sformatf("%s_rdata%0d", tag, i), rb, v.d[i]);
        end
        wclk(4);
        chk($sformatf("%s_sda_rel_after_nack", tag), bus.sda_out, 1);
      end
    end
    i2c_stop(v.ack);
    chk($sformatf("%s_sda_idle", tag), bus.sda_out, 1);
    chk($sformatf("%s_strobes", tag), strobe_cnt - sc0, (v.ack && !v.rd) ? int'(v.n) : 0);
    if (v.ack && !v.rd && v.n != 0) begin
      chk($sformatf("%s_last_wr_addr", tag), last_wa, (v.ptr + v.n - 1) % 8);
      chk($sformatf("%s_last_wr_data", tag), last_wd, v.d[v.n-1]);
    end
  endtask

  vec_t tbl [6];

  initial begin
    vec_t       v;
    logic       ack;
    logic       s;
    int         sc0;
    int         p;

    tbl[0] = '{addr: 7'h50, rd: 1'b0, ptr: 8'h02, n: 3'd2, d: 32'h0000_3CA5, ack: 1'b1};
    tbl[1] = '{addr: 7'h50, rd: 1'b0, ptr: 8'h07, n: 3'd2, d: 32'h0000_2211, ack: 1'b1};
    tbl[2] = '{addr: 7'h50, rd: 1'b1, ptr: 8'h02, n: 3'd2, d: 32'h0000_3CA5, ack: 1'b1};
    tbl[3] = '{addr: 7'h51, rd: 1'b0, ptr: 8'h00, n: 3'd1, d: 32'h0000_0077, ack: 1'b0};
    tbl[4] = '{addr: 7'h50, rd: 1'b1, ptr: 8'hF7, n: 3'd2, d: 32'h0000_2211, ack: 1'b1};
    tbl[5] = '{addr: 7'h00, rd: 1'b0, ptr: 8'h00, n: 3'd1, d: 32'h0000_0055, ack: 1'b0};

    for (int i = 0; i < 8; i++) m[i] = 8'h00;
    rst_n        = 1'b0;
    bus.scl_in   = 1'b1;
    bus.sda_in   = 1'b1;
    bus.dbg_addr = 3'd0;
    wclk(3);
    chk("rst_sda_out", bus.sda_out, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wr_strobe", bus.wr_strobe, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    for (int i = 0; i < 8; i++) begin
      bus.dbg_addr = 3'(i);
      #1;
      chk($sformatf("rst_mem%0d", i), bus.dbg_data, 0);
    end
    rst_n = 1'b1;
    wclk(4);

    for (int i = 0; i < 6; i++) xfer(tbl[i], $sformatf("vec%0d", i));

    for (int it = 0; it < 10; it++) begin
      v.addr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h50;
      v.ack  = (v.addr == 7'h50);
      v.rd   = 1'b0;
      v.ptr  = 8'($urandom);
      v.n    = 3'($urandom_range(1, 3));
      v.d    = 32'($urandom);
      xfer(v, $sformatf("rw%0d", it));
      v.addr = 7'h50;
      v.ack  = 1'b1;
      v.rd   = 1'b1;
      v.ptr  = 8'($urandom);
      v.n    = 3'($urandom_range(1, 3));
      p      = v.ptr % 8;
      for (int k = 0; k < 4; k++) begin
        v.d[k] = m[p];
        p = (p + 1) % 8;
      end
      xfer(v, $sformatf("rr%0d", it));
    end

    // Repeated START after 4 data bits must discard the partial byte
    sc0 = strobe_cnt;
    i2c_start();
    wr_byte({7'h50, 1'b0}, ack);
    wr_byte(8'h04, ack);
    for (int i = 0; i < 4; i++) send_bit(1'(i % 2 == 0), s);
    i2c_start();
    wr_byte({7'h50, 1'b0}, ack);
    chk("rstart_addr_ack", ack, 1);
    wr_byte(8'h05, ack);
    chk("rstart_ptr_ack", ack, 1);
    i2c_stop(1'b1);
    chk("rstart_no_strobe", strobe_cnt - sc0, 0);

    for (int i = 0; i < 8; i++) begin
      bus.dbg_addr = 3'(i);
      #1;
      chk($sformatf("model_mem%0d", i), bus.dbg_data, m[i]);
    end

    // Reset while the target is pulling SDA low for a read bit
    v = '{addr: 7'h50, rd: 1'b0, ptr: 8'h01, n: 3'd1, d: 32'h0000_000F, ack: 1'b1};
    xfer(v, "pre_rst");
    i2c_start();
    wr_byte({7'h50, 1'b0}, ack);
    wr_byte(8'h01, ack);
    i2c_start();
    wr_byte({7'h50, 1'b1}, ack);
    chk("rst_rd_addr_ack", ack, 1);
    wclk(5);
    chk("rst_rd_msb_driven", bus.sda_out, 0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_sda_release", bus.sda_out, 1);
    chk("rst_async_busy", bus.busy, 0);
    for (int i = 0; i < 8; i++) begin
      bus.dbg_addr = 3'(i);
      #1;
      chk($sformatf("rst_clr_mem%0d", i), bus.dbg_data, 0);
    end
    bus.scl_in = 1'b1;
    bus.sda_in = 1'b1;
    wclk(4);
    rst_n = 1'b1;
    wclk(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
